// File: rtl/lsu_writeback.sv
// rtl/lsu_writeback.sv - load/store + writeback stage on an AXI4-Lite master; optional LSU_TIMEOUT_EN bus timeout
module lsu_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0]   in_alu_result,
    input  logic [DATA_WIDTH-1:0]   in_wdata,
    input  logic                    in_mem_read,
    input  logic                    in_mem_write,
    input  logic [1:0]              in_size,
    input  logic                    in_unsigned,
    input  logic [1:0]              in_result_src,
    input  logic [DATA_WIDTH-1:0]   in_csr_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic [ADDR_WIDTH-1:0]   out_pc,
    output logic                    out_err,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW_W = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            state_q;
    logic                  started_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] alu_q, wdata_q, csr_q, load_q;
    logic [1:0]            size_q, src_q;
    logic                  uns_q, err_q, aw_pend_q, w_pend_q;

    logic                  misaligned;
    logic [OFFW-1:0]       offset;
    logic [DATA_WIDTH-1:0] shifted, ext_load, wdata_rep;
    logic [NB-1:0]         lane_mask;
    logic [ADDR_WIDTH-1:0] pc4;

    assign offset = alu_q[OFFW-1:0];
    assign pc4    = pc_q + ADDR_WIDTH'(4);

    // size=3 (set mask 7) is a dword; it cannot exist on a 32-bit bus at all
    assign misaligned = ((in_alu_result[2:0] & ((3'd1 << in_size) - 3'd1)) != 3'd0) ||
                        (in_size == 2'd3 && DATA_WIDTH == 32);

    assign shifted = m_rdata >> {offset, 3'b000};

    always_comb begin
        ext_load  = shifted;
        wdata_rep = wdata_q;
        lane_mask = {NB{1'b1}};
        case (size_q)
            2'd0: begin
                ext_load  = uns_q ? DATA_WIDTH'(shifted[7:0]) : DATA_WIDTH'($signed(shifted[7:0]));
                wdata_rep = {NB{wdata_q[7:0]}};
                lane_mask = NB'(1);
            end
            2'd1: begin
                ext_load  = uns_q ? DATA_WIDTH'(shifted[15:0]) : DATA_WIDTH'($signed(shifted[15:0]));
                wdata_rep = {(NB/2){wdata_q[15:0]}};
                lane_mask = NB'(3);
            end
            2'd2: begin
                ext_load  = uns_q ? DATA_WIDTH'(shifted[31:0]) : DATA_WIDTH'($signed(shifted[31:0]));
                wdata_rep = {(NB/4){wdata_q[31:0]}};
                lane_mask = NB'(15);
            end
            default: ;
        endcase
    end

    assign in_ready  = started_q && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_pc    = pc_q;
    assign out_err   = err_q;
    assign m_araddr  = ADDR_WIDTH'(alu_q);
    assign m_awaddr  = ADDR_WIDTH'(alu_q);
    assign m_arvalid = (state_q == S_AR);
    assign m_rready  = (state_q == S_R);
    assign m_awvalid = (state_q == S_AW_W) && aw_pend_q;
    assign m_wvalid  = (state_q == S_AW_W) && w_pend_q;
    assign m_wdata   = wdata_rep;
    assign m_wstrb   = (state_q == S_AW_W) ? (lane_mask << offset) : '0;
    assign m_bready  = (state_q == S_B);

    always_comb begin
        case (src_q)
            2'd0:    out_result = alu_q;
            2'd1:    out_result = load_q;
            2'd2:    out_result = DATA_WIDTH'(pc4);
            default: out_result = csr_q;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        busy, tmo_hit;
    assign busy    = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW_W) || (state_q == S_B);
    assign tmo_hit = busy && (tmo_q >= 32'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       tmo_q <= '0;
        else if (!busy)  tmo_q <= '0;
        else             tmo_q <= tmo_q + 32'd1;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            started_q <= 1'b0;
            pc_q      <= '0;
            alu_q     <= '0;
            wdata_q   <= '0;
            csr_q     <= '0;
            load_q    <= '0;
            size_q    <= '0;
            src_q     <= '0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            started_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
            if (tmo_hit) begin
                state_q <= S_DONE;
                err_q   <= 1'b1;
                load_q  <= '0;
            end else
`endif
            case (state_q)
                S_IDLE: if (in_valid && in_ready) begin
                    pc_q      <= in_pc;
                    alu_q     <= in_alu_result;
                    wdata_q   <= in_wdata;
                    csr_q     <= in_csr_rdata;
                    size_q    <= in_size;
                    src_q     <= in_result_src;
                    uns_q     <= in_unsigned;
                    load_q    <= '0;
                    aw_pend_q <= 1'b1;
                    w_pend_q  <= 1'b1;
                    err_q     <= misaligned && (in_mem_read || in_mem_write);
                    if ((in_mem_read || in_mem_write) && misaligned) state_q <= S_DONE;
                    else if (in_mem_read)                            state_q <= S_AR;
                    else if (in_mem_write)                           state_q <= S_AW_W;
                    else                                             state_q <= S_DONE;
                end
                S_AR: if (m_arready) state_q <= S_R;
                S_R: if (m_rvalid) begin
                    err_q   <= (m_rresp != 2'b00);
                    load_q  <= (m_rresp != 2'b00) ? '0 : ext_load;
                    state_q <= S_DONE;
                end
                S_AW_W: begin
                    if (m_awready) aw_pend_q <= 1'b0;
                    if (m_wready)  w_pend_q  <= 1'b0;
                    if ((!aw_pend_q || m_awready) && (!w_pend_q || m_wready)) state_q <= S_B;
                end
                S_B: if (m_bvalid) begin
                    err_q   <= (m_bresp != 2'b00);
                    state_q <= S_DONE;
                end
                S_DONE: if (out_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Parametrised load/store + writeback stage. It accepts one executed instruction per handshake.
- Memory ops run on a single AXI4-Lite master port; target decode and arbitration are done outside the block.
- Loads are lane-extracted and sign/zero extended. The final register-file result is selected from ALU, load data, pc+4 or CSR.
- Successor to the fixed 32-bit SRAM/UART writeback unit. Adds width generality, byte/half/word alignment, bus-error and misalignment reporting, and a valid/ready output stage.

Parameters:
DATA_WIDTH, 32, bus/register width; 32 or 64 only
ADDR_WIDTH, 32, address width
TIMEOUT, 255, bus wait limit in cycles (used only with LSU_TIMEOUT_EN)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept
in_pc  in  ADDR_WIDTH  instruction pc
in_alu_result  in  DATA_WIDTH  ALU result / memory address
in_wdata  in  DATA_WIDTH  store data (LSB-aligned)
in_mem_read  in  1  load op
in_mem_write  in  1  store op
in_size  in  2  0=byte,1=half,2=word,3=dword
in_unsigned  in  1  zero-extend load
in_result_src  in  2  0=ALU,1=load,2=pc+4,3=CSR
in_csr_rdata  in  DATA_WIDTH  CSR read value
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  DATA_WIDTH  writeback value
out_pc  out  ADDR_WIDTH  latched pc
out_err  out  1  access fault (bus error/misaligned/timeout)
m_araddr, m_arvalid / m_arready  out,out / in  ADDR_WIDTH,1 / 1  AXI read address
m_rdata, m_rresp, m_rvalid / m_rready  in,in,in / out  DATA_WIDTH,2,1 / 1  AXI read data
m_awaddr, m_awvalid / m_awready  out,out / in  ADDR_WIDTH,1 / 1  AXI write address
m_wdata, m_wstrb, m_wvalid / m_wready  out,out,out / in  DATA_WIDTH,DATA_WIDTH/8,1 / 1  AXI write data
m_bresp, m_bvalid / m_bready  in,in / out  2,1 / 1  AXI write response

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE immediately, including mid-transaction.
  - All outputs are 0, including all AXI valids/readies.
  - in_ready rises the first clk after rstn deasserts.
- States: IDLE, AR, R, AW_W, B, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch all in_* fields.
  - Next state:
    - Misaligned (addr offset not a multiple of 1<<size, or size=3 with DATA_WIDTH=32) with read or write → DONE with err=1; no bus traffic.
    - Read (wins if read and write are both set) → AR.
    - Write → AW_W.
    - Otherwise → DONE.
  - Non-memory latency: out_valid 1 cycle after accept.
- AR: m_arvalid=1, m_araddr=latched address (unmodified). Hold until m_arready, then go to R.
- R:
  - m_rready=1 until m_rvalid.
  - Capture lane at byte offset addr[log2(DATA_WIDTH/8)-1:0]; extend per size/in_unsigned.
  - m_rresp!=0 → err=1, load data=0.
  - Go to DONE.
- AW_W:
  - m_awvalid and m_wvalid both assert on entry; each drops independently after its own handshake (same-cycle both allowed).
  - m_wdata = in_wdata replicated into all lanes. m_wstrb = ((1<<(1<<size))-1) << offset.
  - Go to B once both handshakes are complete.
- B: m_bready=1 until m_bvalid; m_bresp!=0 → err=1. Go to DONE.
- DONE:
  - out_valid=1 with stable out_result/out_pc/out_err until out_ready.
  - Then IDLE, or, when out_ready arrives, back-to-back accept is not allowed; in_ready=0 in DONE.
- Result mux:
  - 0 = latched ALU
  - 1 = extended load data
  - 2 = pc+4 (zero-extended to DATA_WIDTH)
  - 3 = CSR
  - out_err forces nothing in the mux; it is reported alongside the result.
- Valids never drop before their handshake (except reset/timeout abort).

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to AR/AW_W and increments every cycle in AR, R, AW_W and B.
  - When it reaches TIMEOUT, all AXI valids/readies drop and the block goes to DONE with out_err=1 and load data=0.
- Undefined: the block waits indefinitely and the counter is not instantiated.

Test Plan:
- ALU op, src=0, alu=0x1234, out_ready=1 → out_valid 1 cycle after accept, out_result=0x1234, out_err=0, no AXI activity.
- LB addr 0x8000_0003, rdata 0x80FF_FFFF, rresp=0 → m_araddr=0x8000_0003, out_result=0xFFFF_FF80. Same with in_unsigned=1 → 0x0000_0080.
- SH addr 0x102, wdata 0xABCD, awready delayed 3 cycles, wready immediate → m_wstrb=4'b1100, m_wdata=0xABCD_ABCD, wvalid drops after 1 cycle, out_valid after bvalid.
- LW addr 0x101 → no arvalid, out_err=1. SW with bresp=2'b10 → out_err=1.
- rstn pulsed low while in R → m_rready=0 immediately, state IDLE, in_ready=1 after release.
- LSU_TIMEOUT_EN, TIMEOUT=8, arready held 0 → arvalid drops after 8 cycles, out_err=1, out_result=0 for src=1.
